// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader placed in front of the micro computer's program
// RAM. It keeps the CPU halted while a program image arrives as a byte stream,
// writes the image to RAM addresses 0..DEPTH-1, and then checks one trailing
// checksum byte. The CPU is released through cpu_run only when the modulo
// 2^DATA_W sum of all image bytes plus the checksum is zero. A bad checksum
// parks the loader in an error state that only a new start can leave.
//
// Ports
//   clk       in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   one-cycle request to begin or restart a load
//   in_data   in   stream byte
//   in_valid  in   in_data is valid
//   in_ready  out  byte can be accepted this cycle (combinational)
//   mem_addr  out  RAM write address (registered)
//   mem_data  out  RAM write data (registered)
//   mem_we    out  RAM write strobe, one cycle per word (registered)
//   busy      out  loading or waiting for the checksum
//   done      out  one-cycle pulse after a good checksum
//   err       out  level, bad checksum seen
//   cpu_run   out  level, CPU may run
//   sum       out  running modulo-2^DATA_W sum of accepted bytes
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run,
    output logic [DATA_W-1:0] sum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [DATA_W-1:0] sum_reg, sum_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_data_reg, mem_data_next;
    logic              mem_we_reg, mem_we_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic              xfer;
    logic [DATA_W-1:0] sum_plus;

    // start blocks the handshake so a byte presented alongside a restart is
    // never half-accepted; the sender has to present it again.
    assign in_ready = ((state_reg == LOAD) || (state_reg == CHECK)) && !start;
    assign xfer     = in_valid && in_ready;
    assign sum_plus = sum_reg + in_data;

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        sum_next      = sum_reg;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        mem_we_next   = 1'b0;
        done_next     = 1'b0;

        if (start) begin
            state_next = LOAD;
            index_next = '0;
            sum_next   = '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (xfer) begin
                        mem_addr_next = index_reg;
                        mem_data_next = in_data;
                        mem_we_next   = 1'b1;
                        sum_next      = sum_plus;
                        // The index saturates at the last word; the next byte
                        // is the checksum, so there is no wrap to address 0.
                        if (index_reg == LAST_IDX) begin
                            state_next = CHECK;
                        end else begin
                            index_next = index_reg + ADDR_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        // Checksum byte: folded into sum but never written.
                        sum_next = sum_plus;
                        if (sum_plus == '0) begin
                            state_next = RUN;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ERROR;
                        end
                    end
                end
                default: begin
                    // IDLE, RUN and ERROR ignore the stream entirely.
                end
            endcase
        end

        busy_next = (state_next == LOAD) || (state_next == CHECK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            sum_reg      <= '0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_we_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            sum_reg      <= sum_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            mem_we_reg   <= mem_we_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign mem_we   = mem_we_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sum      = sum_reg;
    // Decoded straight from the state register, so both are glitch-free levels.
    assign err      = (state_reg == ERROR);
    assign cpu_run  = (state_reg == RUN);

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed sequence with randomized image bytes and stall patterns. Expected
// values come from a plain arithmetic model: the image array, a running sum of
// accepted bytes, and "good = (sum of image + checksum) mod 256 == 0".
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b1;
    logic              start    = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_run;
    logic [DATA_W-1:0] sum;

    prog_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_run  (cpu_run),
        .sum      (sum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] img [DEPTH];
    logic [7:0] tb_ram [DEPTH];
    int         wr_total = 0;

    // RAM model driven by the write port.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            tb_ram[mem_addr] <= mem_data;
            wr_total         <= wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit with_valid, input logic [7:0] byte_val);
        in_valid = with_valid;
        in_data  = byte_val;
        start    = 1'b1;
        #1;
        chk("start_in_ready", 32'(in_ready), 32'd0);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_sum",     32'(sum),     32'd0);
        chk("start_mem_we",  32'(mem_we),  32'd0);
        chk("start_cpu_run", 32'(cpu_run), 32'd0);
        chk("start_err",     32'(err),     32'd0);
        chk("start_done",    32'(done),    32'd0);
        chk("start_busy",    32'(busy),    32'd1);
    endtask

    // Sends up to 'limit' transfers (DEPTH data bytes then the checksum).
    task automatic send_image(input bit stall, input logic [7:0] cks,
                              input int limit, output int n_edges);
        int k;
        int base;
        int acc;
        bit good;
        k       = 0;
        n_edges = 0;
        acc     = 0;
        base    = wr_total;
        while (k < limit && n_edges < 4000) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = (k < DEPTH) ? img[k] : cks;
            #1;
            chk("in_ready", 32'(in_ready), 32'd1);
            chk("busy",     32'(busy),     32'd1);
            tick();
            n_edges++;
            if (in_valid) begin
                acc = (acc + int'(in_data)) & 255;
                if (k < DEPTH) begin
                    chk("wr_we",   32'(mem_we),   32'd1);
                    chk("wr_addr", 32'(mem_addr), 32'(k));
                    chk("wr_data", 32'(mem_data), 32'(img[k]));
                    chk("wr_sum",  32'(sum),      32'(acc));
                end
                k++;
            end else begin
                chk("stall_mem_we", 32'(mem_we), 32'd0);
            end
        end
        in_valid = 1'b0;
        chk("xfer_count", 32'(k), 32'(limit));
        if (limit == DEPTH + 1) begin
            good = (acc == 0);
            chk("end_cpu_run",  32'(cpu_run), 32'(good));
            chk("end_err",      32'(err),     32'(!good));
            chk("end_done",     32'(done),    32'(good));
            chk("end_busy",     32'(busy),    32'd0);
            chk("end_sum",      32'(sum),     32'(acc));
            chk("cks_no_write", 32'(mem_we),  32'd0);
            chk("write_count",  32'(wr_total - base), 32'(DEPTH));
            for (int i = 0; i < DEPTH; i++) begin
                chk("ram", 32'(tb_ram[i]), 32'(img[i]));
            end
            tick();
            chk("done_pulse", 32'(done),    32'd0);
            chk("run_hold",   32'(cpu_run), 32'(good));
            chk("err_hold",   32'(err),     32'(!good));
            $display("image: stall=%0d cks=%02h edges=%0d sum=%02h run=%0d err=%0d",
                     stall, cks, n_edges, acc, cpu_run, err);
        end
    endtask

    function automatic logic [7:0] good_cks();
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(img[i]);
        return 8'((256 - (s & 255)) & 255);
    endfunction

    initial begin
        int n;
        int base;

        // ---- reset values ----
        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_cpu_run",  32'(cpu_run),  32'd0);
        chk("rst_sum",      32'(sum),      32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // ---- ignored in IDLE ----
        base     = wr_total;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_sum",    32'(sum),    32'd0);
        chk("idle_busy",   32'(busy),   32'd0);
        chk("idle_writes", 32'(wr_total - base), 32'd0);

        // ---- nominal load: 16 x 0x01, checksum 0xF0 ----
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h01;
        do_start(1'b0, 8'h00);
        send_image(1'b0, 8'hF0, DEPTH + 1, n);
        // start edge + DEPTH+1 transfer edges until cpu_run is visible
        chk("run_latency", 32'(n + 1), 32'(DEPTH + 2));

        // ---- ignored in RUN ----
        base     = wr_total;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        chk("run_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        chk("run_mem_we",  32'(mem_we),  32'd0);
        chk("run_sum",     32'(sum),     32'd0);
        chk("run_cpu_run", 32'(cpu_run), 32'd1);
        chk("run_writes",  32'(wr_total - base), 32'd0);

        // ---- bad checksum, then recovery with a random good image ----
        do_start(1'b0, 8'h00);
        send_image(1'b0, 8'hF1, DEPTH + 1, n);
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        do_start(1'b0, 8'h00);
        send_image(1'b0, good_cks(), DEPTH + 1, n);

        // ---- stalls: image 0x00..0x0F, checksum 0x88 ----
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        do_start(1'b0, 8'h00);
        send_image(1'b1, 8'h88, DEPTH + 1, n);

        // ---- start collides with the 6th byte ----
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom_range(1, 255));
        do_start(1'b0, 8'h00);
        send_image(1'b0, 8'h00, 5, n);
        do_start(1'b1, img[5]);
        send_image(1'b0, good_cks(), DEPTH + 1, n);

        // ---- async reset after 9 bytes ----
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        do_start(1'b0, 8'h00);
        send_image(1'b0, 8'h00, 9, n);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_mem_we",   32'(mem_we),   32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        chk("arst_mem_data", 32'(mem_data), 32'd0);
        chk("arst_busy",     32'(busy),     32'd0);
        chk("arst_sum",      32'(sum),      32'd0);
        chk("arst_cpu_run",  32'(cpu_run),  32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        base = wr_total;
        tick();
        tick();
        chk("arst_writes", 32'(wr_total - base), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("arst_cpu_idle", 32'(cpu_run), 32'd0);
        do_start(1'b0, 8'h00);
        send_image(1'b0, good_cks(), DEPTH + 1, n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
